// File: rtl/pawn_move_writer_if.sv
// Request/checker/board bundle between a move requester and the pawn move writer.
// The requester side also supplies the pawn checker's allow vector.
interface pawn_move_writer_if #(parameter int CAP_W = 4);
  logic                   move_valid;
  logic                   move_ready;
  logic [2:0]             move_row;
  logic [2:0]             move_col;
  logic                   move_color;
  logic [1:0]             move_dir;
  logic [2:0]             chk_row;
  logic [2:0]             chk_col;
  logic                   chk_color;
  logic [2:0]             chk_allow;
  logic [2:0][7:0][7:0]   boardPos;
  logic                   done;
  logic                   accepted;
  logic                   captured;
  logic [CAP_W-1:0]       white_caps;
  logic [CAP_W-1:0]       black_caps;
  logic                   game_over;

  modport master (
    output move_valid, move_row, move_col, move_color, move_dir, chk_allow,
    input  move_ready, chk_row, chk_col, chk_color, boardPos, done, accepted,
           captured, white_caps, black_caps, game_over
  );

  modport slave (
    input  move_valid, move_row, move_col, move_color, move_dir, chk_allow,
    output move_ready, chk_row, chk_col, chk_color, boardPos, done, accepted,
           captured, white_caps, black_caps, game_over
  );
endinterface

// File: rtl/pawn_move_writer.sv
// Owns the 8x8 board register and applies pawn moves: IDLE -> CHECK -> WRITE -> RESP.
// boardPos is indexed [bit][row][col]; bit0 occupied, bit1 black, bit2 king.
module pawn_move_writer #(
  parameter int CAP_W = 4
) (
  input logic              clk,
  input logic              reset,
  pawn_move_writer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CHECK, WRITE, RESP} state_e;
  typedef logic [2:0][7:0][7:0] board_t;

  state_e           state_q;
  board_t           board_q;
  logic             ready_q, done_q, accepted_q, captured_q, legal_q, game_over_q;
  logic [2:0]       row_q, col_q, dst_row_q, dst_col_q;
  logic             color_q;
  logic [1:0]       dir_q;
  logic [CAP_W-1:0] wcaps_q, bcaps_q;

  logic [3:0]       dst_row_d, dst_col_d;
  logic [2:0]       src_sq, dst_sq;
  logic             allow_d, legal_d;

  function automatic board_t reset_board();
    board_t b;
    b = '0;
    for (int c = 0; c < 8; c++) begin
      b[0][1][c] = 1'b1;
      b[1][1][c] = 1'b1;
      b[0][6][c] = 1'b1;
    end
    b[0][0][4] = 1'b1; b[1][0][4] = 1'b1; b[2][0][4] = 1'b1;
    b[0][7][4] = 1'b1; b[2][7][4] = 1'b1;
    return b;
  endfunction

  // Destination is formed at 4 bits so that stepping off either edge sets bit3.
  always_comb begin
    dst_row_d = color_q ? {1'b0, row_q} + 4'd1 : {1'b0, row_q} - 4'd1;
    dst_col_d = {1'b0, col_q};
    allow_d   = 1'b0;
    case (dir_q)
      2'b00: allow_d = bus.chk_allow[2];
      2'b01: begin allow_d = bus.chk_allow[1]; dst_col_d = {1'b0, col_q} - 4'd1; end
      2'b10: begin allow_d = bus.chk_allow[0]; dst_col_d = {1'b0, col_q} + 4'd1; end
      default: allow_d = 1'b0;
    endcase
    src_sq  = {board_q[2][row_q][col_q], board_q[1][row_q][col_q], board_q[0][row_q][col_q]};
    dst_sq  = {board_q[2][dst_row_q][dst_col_q], board_q[1][dst_row_q][dst_col_q],
               board_q[0][dst_row_q][dst_col_q]};
    legal_d = (dir_q != 2'b11) && allow_d && (src_sq == {1'b0, color_q, 1'b1}) &&
              !game_over_q && !dst_row_d[3] && !dst_col_d[3];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      board_q     <= reset_board();
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      accepted_q  <= 1'b0;
      captured_q  <= 1'b0;
      legal_q     <= 1'b0;
      game_over_q <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      color_q     <= 1'b0;
      dir_q       <= '0;
      dst_row_q   <= '0;
      dst_col_q   <= '0;
      wcaps_q     <= '0;
      bcaps_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.move_valid && ready_q) begin
            row_q   <= bus.move_row;
            col_q   <= bus.move_col;
            color_q <= bus.move_color;
            dir_q   <= bus.move_dir;
            ready_q <= 1'b0;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          legal_q   <= legal_d;
          dst_row_q <= dst_row_d[2:0];
          dst_col_q <= dst_col_d[2:0];
          state_q   <= WRITE;
        end
        WRITE: begin
          if (legal_q) begin
            for (int b = 0; b < 3; b++) board_q[b][row_q][col_q] <= 1'b0;
            board_q[0][dst_row_q][dst_col_q] <= 1'b1;
            board_q[1][dst_row_q][dst_col_q] <= color_q;
            board_q[2][dst_row_q][dst_col_q] <= 1'b0;
            captured_q <= dst_sq[0];
            if (dst_sq[0]) begin
              if (color_q) begin
                if (bcaps_q != '1) bcaps_q <= bcaps_q + CAP_W'(1);
              end else begin
                if (wcaps_q != '1) wcaps_q <= wcaps_q + CAP_W'(1);
              end
            end
            if (dst_sq[2]) game_over_q <= 1'b1;
          end else begin
            captured_q <= 1'b0;
          end
          done_q     <= 1'b1;
          accepted_q <= legal_q;
          state_q    <= RESP;
        end
        RESP: begin
          done_q     <= 1'b0;
          accepted_q <= 1'b0;
          captured_q <= 1'b0;
          ready_q    <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.move_ready = ready_q;
  assign bus.chk_row    = row_q;
  assign bus.chk_col    = col_q;
  assign bus.chk_color  = color_q;
  assign bus.boardPos   = board_q;
  assign bus.done       = done_q;
  assign bus.accepted   = accepted_q;
  assign bus.captured   = captured_q;
  assign bus.white_caps = wcaps_q;
  assign bus.black_caps = bcaps_q;
  assign bus.game_over  = game_over_q;
endmodule

// File: tb/tb_pawn_move_writer.sv
// Directed bench for pawn_move_writer; expected responses queue at handshake, pop at done.
module tb_pawn_move_writer;
  localparam int CAP_W = 4;
  localparam logic [CAP_W-1:0] CAP_MAX = '1;
  typedef logic [2:0][7:0][7:0] board_t;
  typedef struct packed { logic acc; logic cap; } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pawn_move_writer_if #(.CAP_W(CAP_W)) bus();
  pawn_move_writer #(.CAP_W(CAP_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  exp_t             sb[$];
  exp_t             got;
  int               n_cmp = 0;
  int               n_bad = 0;
  logic [2:0]       mb[8][8];
  logic [CAP_W-1:0] exp_w, exp_b;
  logic             exp_go;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic init_model();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mb[r][c] = 3'b000;
    for (int c = 0; c < 8; c++) begin
      mb[1][c] = 3'b011;
      mb[6][c] = 3'b001;
    end
    mb[0][4] = 3'b111;
    mb[7][4] = 3'b101;
    exp_w  = '0;
    exp_b  = '0;
    exp_go = 1'b0;
  endtask

  function automatic board_t model_vec();
    board_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        for (int k = 0; k < 3; k++) b[k][r][c] = mb[r][c][k];
    return b;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    init_model();
    sb.delete();
  endtask

  task automatic do_move(input int r, input int c, input logic clr, input logic [1:0] d,
                         input logic [2:0] allow, input logic eacc, input logic ecap,
                         input int dr, input int dc);
    int   n;
    exp_t e;
    @(negedge clk);
    bus.move_valid = 1'b1;
    bus.move_row   = 3'(r);
    bus.move_col   = 3'(c);
    bus.move_color = clr;
    bus.move_dir   = d;
    bus.chk_allow  = allow;
    n = 0;
    while (!bus.move_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("hs_wait", bus.move_ready, 1'b1);
    sb.push_back('{eacc, ecap});
    if (eacc) begin
      if (mb[dr][dc][2]) exp_go = 1'b1;
      if (ecap) begin
        if (clr) begin
          if (exp_b != CAP_MAX) exp_b++;
        end else begin
          if (exp_w != CAP_MAX) exp_w++;
        end
      end
      mb[r][c]   = 3'b000;
      mb[dr][dc] = {1'b0, clr, 1'b1};
    end
    @(negedge clk);
    bus.move_valid = 1'b0;
    check("chk_pos", {bus.chk_color, bus.chk_row, bus.chk_col}, {clr, 3'(r), 3'(c)});
    n = 1;
    while (!bus.done && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, 3);
    if (bus.done && sb.size() > 0) begin
      e = sb.pop_front();
      check("accepted", bus.accepted, e.acc);
      check("captured", bus.captured, e.cap);
    end
    check("board", bus.boardPos, model_vec());
    check("caps", {bus.white_caps, bus.black_caps}, {exp_w, exp_b});
    check("game_over", bus.game_over, exp_go);
    @(negedge clk);
    check("done_pulse", {bus.done, bus.move_ready}, 2'b01);
  endtask

  initial begin
    bus.move_valid = 1'b0;
    bus.move_row   = '0;
    bus.move_col   = '0;
    bus.move_color = 1'b0;
    bus.move_dir   = '0;
    bus.chk_allow  = '0;
    do_reset();

    // Reset state
    check("rst_ready", bus.move_ready, 1'b1);
    check("rst_resp", {bus.done, bus.accepted, bus.captured}, 3'b000);
    check("rst_caps", {bus.white_caps, bus.black_caps, bus.game_over}, '0);
    check("rst_chk", {bus.chk_color, bus.chk_row, bus.chk_col}, '0);
    check("rst_board", bus.boardPos, model_vec());

    // Plain forward move
    do_move(6, 3, 1'b0, 2'b00, 3'b100, 1'b1, 1'b0, 5, 3);
    check("fwd_dst", mb[5][3], 3'b001);

    // Bring a black pawn to [5][2], then white diagLeft capture
    do_reset();
    for (int r = 1; r < 5; r++) do_move(r, 2, 1'b1, 2'b00, 3'b100, 1'b1, 1'b0, r + 1, 2);
    do_move(6, 3, 1'b0, 2'b01, 3'b010, 1'b1, 1'b1, 5, 2);
    // Rejections: edge, reserved dir, opponent/empty/king source, allow bit clear
    do_move(6, 0, 1'b0, 2'b01, 3'b111, 1'b0, 1'b0, 0, 0);
    do_move(1, 7, 1'b1, 2'b10, 3'b111, 1'b0, 1'b0, 0, 0);
    do_move(6, 5, 1'b0, 2'b11, 3'b111, 1'b0, 1'b0, 0, 0);
    do_move(1, 5, 1'b0, 2'b00, 3'b111, 1'b0, 1'b0, 0, 0);
    do_move(4, 5, 1'b0, 2'b00, 3'b111, 1'b0, 1'b0, 0, 0);
    do_move(7, 4, 1'b0, 2'b00, 3'b111, 1'b0, 1'b0, 0, 0);
    do_move(6, 5, 1'b0, 2'b00, 3'b011, 1'b0, 1'b0, 0, 0);

    // Reset asserted while the writer is in WRITE
    @(negedge clk);
    bus.move_valid = 1'b1;
    bus.move_row   = 3'd6;
    bus.move_col   = 3'd1;
    bus.move_color = 1'b0;
    bus.move_dir   = 2'b00;
    bus.chk_allow  = 3'b100;
    check("rm_ready", bus.move_ready, 1'b1);
    @(negedge clk);
    bus.move_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    init_model();
    sb.delete();
    @(negedge clk);
    check("rm_done", bus.done, 1'b0);
    check("rm_board", bus.boardPos, model_vec());
    check("rm_ready_next", bus.move_ready, 1'b1);
    check("rm_caps", {bus.white_caps, bus.black_caps}, '0);
    reset = 1'b0;

    // move_valid held through the whole transaction
    @(negedge clk);
    bus.move_valid = 1'b1;
    bus.move_row   = 3'd6;
    bus.move_col   = 3'd0;
    bus.move_color = 1'b0;
    bus.move_dir   = 2'b00;
    bus.chk_allow  = 3'b100;
    check("hold_rdy0", bus.move_ready, 1'b1);
    sb.push_back('{1'b1, 1'b0});
    mb[6][0] = 3'b000;
    mb[5][0] = 3'b001;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("hold_rdy%0d", k), bus.move_ready, k == 4);
      check($sformatf("hold_done%0d", k), bus.done, (k == 3) || (k == 7));
      if (k == 4) sb.push_back('{1'b0, 1'b0});
      if (k == 5) bus.move_valid = 1'b0;
      if (bus.done && sb.size() > 0) begin
        got = sb.pop_front();
        check($sformatf("hold_acc%0d", k), bus.accepted, got.acc);
      end
    end
    check("hold_board", bus.boardPos, model_vec());
    check("hold_sb_empty", sb.size(), 0);

    // Black pawn takes a white pawn and then the white king
    do_reset();
    for (int r = 1; r < 5; r++) do_move(r, 3, 1'b1, 2'b00, 3'b100, 1'b1, 1'b0, r + 1, 3);
    do_move(5, 3, 1'b1, 2'b00, 3'b100, 1'b1, 1'b1, 6, 3);
    do_move(6, 3, 1'b1, 2'b10, 3'b001, 1'b1, 1'b1, 7, 4);
    check("king_go", bus.game_over, 1'b1);
    do_move(6, 0, 1'b0, 2'b00, 3'b100, 1'b0, 1'b0, 0, 0);

    // Fifteen white captures, then a sixteenth that must saturate
    do_reset();
    for (int c = 0; c < 8; c++) begin
      for (int r = 1; r < 5; r++) do_move(r, c, 1'b1, 2'b00, 3'b100, 1'b1, 1'b0, r + 1, c);
      do_move(6, c, 1'b0, 2'b00, 3'b100, 1'b1, 1'b1, 5, c);
    end
    for (int c = 0; c < 8; c += 2) begin
      do_move(5, c, 1'b0, 2'b00, 3'b100, 1'b1, 1'b0, 4, c);
      do_move(5, c + 1, 1'b0, 2'b01, 3'b010, 1'b1, 1'b1, 4, c);
    end
    do_move(4, 0, 1'b0, 2'b10, 3'b001, 1'b1, 1'b0, 3, 1);
    do_move(4, 2, 1'b0, 2'b01, 3'b010, 1'b1, 1'b1, 3, 1);
    do_move(4, 4, 1'b0, 2'b10, 3'b001, 1'b1, 1'b0, 3, 5);
    do_move(4, 6, 1'b0, 2'b01, 3'b010, 1'b1, 1'b1, 3, 5);
    do_move(3, 1, 1'b0, 2'b10, 3'b001, 1'b1, 1'b0, 2, 2);
    do_move(2, 2, 1'b0, 2'b10, 3'b001, 1'b1, 1'b0, 1, 3);
    do_move(3, 5, 1'b0, 2'b01, 3'b010, 1'b1, 1'b0, 2, 4);
    do_move(2, 4, 1'b0, 2'b01, 3'b010, 1'b1, 1'b1, 1, 3);
    check("sat_15", bus.white_caps, 4'd15);
    do_move(1, 3, 1'b0, 2'b10, 3'b001, 1'b1, 1'b1, 0, 4);
    check("sat_hold", bus.white_caps, 4'd15);
    check("sat_go", bus.game_over, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
